// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP frame generator: FSM states,
// RGB565 colour-bar palette and counter sizing.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Index 0 is the left-most bar.
    localparam logic [7:0][15:0] BAR_RGB = {RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
                                            RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE};

    function automatic int cnt_width(input int line_clks, input int lines);
        int m;
        m = (line_clks > lines) ? line_clks : lines;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/dvp_bar_pattern.sv
// Maps a pixel x-position to one of eight equal-width RGB565 colour bars.
module dvp_bar_pattern
    import dvp_pkg::*;
#(
    parameter int H_PIXEL = 640,
    parameter int XW      = 10
) (
    input  logic [XW-1:0] x,
    output logic [15:0]   rgb
);

    localparam int BAR_W = (H_PIXEL / 8 > 0) ? H_PIXEL / 8 : 1;

    logic [XW-1:0] idx;

    assign idx = x / XW'(BAR_W);

    always_comb begin
        rgb = BAR_RGB[7];
        if (int'(idx) < 8) rgb = BAR_RGB[3'(idx)];
    end

endmodule

// File: rtl/dvp_frame_gen.sv
// OV7725-style DVP source: vsync/href/byte RGB565 from a valid/ready pixel stream.
// Built-in colour bars are compiled in with DVP_FRAME_GEN_PATTERN_EN.
module dvp_frame_gen
    import dvp_pkg::*;
#(
    parameter int H_PIXEL  = 640,
    parameter int V_PIXEL  = 480,
    parameter int H_BLANK  = 160,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pattern_sel,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        underrun,
    output logic        busy
);

    localparam int LINE_CLKS = 2 * H_PIXEL + H_BLANK;
    localparam int MAX_A     = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
    localparam int MAX_B     = (V_PIXEL > V_FRONT) ? V_PIXEL : V_FRONT;
    localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW        = cnt_width(LINE_CLKS, MAX_LINES);

    state_t          state_q, state_d, next_state;
    logic [CW-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic            eof_q, eof_d;
    logic [7:0]      pix_lo_q, pix_lo_d;
    logic            vsync_q, vsync_d, href_q, href_d, done_q, done_d;
    logic            under_q, under_d, busy_q, busy_d;
    logic [7:0]      data_q, data_d;
    logic            line_end, last_line, frame_end, in_href, stream_mode;
    logic [15:0]     pix_cur;
    int              state_lines;
    state_t          frame_next;

`ifdef DVP_FRAME_GEN_PATTERN_EN
    logic            pattern_q, pattern_d;
    logic [15:0]     bar_rgb;

    dvp_bar_pattern #(.H_PIXEL(H_PIXEL), .XW(CW)) u_bars (
        .x   (hcnt_q >> 1),
        .rgb (bar_rgb)
    );

    assign stream_mode = !pattern_q;
    assign pix_cur     = stream_mode ? (pix_valid ? pix_data : 16'h0000) : bar_rgb;
`else
    logic            unused_pattern_sel;

    assign unused_pattern_sel = pattern_sel;
    assign stream_mode        = 1'b1;
    assign pix_cur            = pix_valid ? pix_data : 16'h0000;
`endif

    always_comb begin
        state_lines = VS_LINES;
        case (state_q)
            ST_VBACK:  state_lines = V_BACK;
            ST_ACTIVE: state_lines = V_PIXEL;
            ST_VFRONT: state_lines = V_FRONT;
            default:   state_lines = VS_LINES;
        endcase
    end

    assign line_end   = (int'(hcnt_q) == LINE_CLKS - 1);
    assign last_line  = (int'(vcnt_q) == state_lines - 1);
    assign frame_end  = line_end && last_line &&
                        (state_q == ST_VFRONT || (state_q == ST_ACTIVE && V_FRONT == 0));
    assign frame_next = en ? ST_VSYNC : ST_IDLE;
    assign in_href    = (state_q == ST_ACTIVE) && (int'(hcnt_q) < 2 * H_PIXEL);
    assign pix_ready  = in_href && !hcnt_q[0] && stream_mode;

    // Zero-length back/front porches are skipped entirely.
    always_comb begin
        next_state = ST_IDLE;
        case (state_q)
            ST_VSYNC:  next_state = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
            ST_VBACK:  next_state = ST_ACTIVE;
            ST_ACTIVE: next_state = (V_FRONT > 0) ? ST_VFRONT : frame_next;
            ST_VFRONT: next_state = frame_next;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
`ifdef DVP_FRAME_GEN_PATTERN_EN
        pattern_d = pattern_q;
        if ((state_q == ST_IDLE || frame_end) && en) pattern_d = pattern_sel;
`endif
        if (state_q == ST_IDLE) begin
            if (en) begin
                state_d = ST_VSYNC;
                hcnt_d  = '0;
                vcnt_d  = '0;
            end
        end else begin
            hcnt_d = line_end ? '0 : hcnt_q + CW'(1);
            if (line_end) begin
                vcnt_d = last_line ? '0 : vcnt_q + CW'(1);
                if (last_line) state_d = next_state;
            end
        end
        eof_d = frame_end;
    end

    // Pin registers sit one clock behind the counters; the low byte is held
    // from the pixel taken on the preceding even clock.
    always_comb begin
        vsync_d  = (state_q == ST_VSYNC);
        href_d   = in_href;
        busy_d   = (state_q != ST_IDLE);
        done_d   = eof_q;
        under_d  = under_q | (pix_ready & ~pix_valid);
        pix_lo_d = pix_lo_q;
        data_d   = 8'h00;
        if (in_href) begin
            if (!hcnt_q[0]) begin
                data_d   = pix_cur[15:8];
                pix_lo_d = pix_cur[7:0];
            end else begin
                data_d   = pix_lo_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            eof_q    <= 1'b0;
            pix_lo_q <= 8'h00;
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            data_q   <= 8'h00;
            done_q   <= 1'b0;
            under_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef DVP_FRAME_GEN_PATTERN_EN
            pattern_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            eof_q    <= eof_d;
            pix_lo_q <= pix_lo_d;
            vsync_q  <= vsync_d;
            href_q   <= href_d;
            data_q   <= data_d;
            done_q   <= done_d;
            under_q  <= under_d;
            busy_q   <= busy_d;
`ifdef DVP_FRAME_GEN_PATTERN_EN
            pattern_q <= pattern_d;
`endif
        end
    end

    assign cam_vsync  = vsync_q;
    assign cam_href   = href_q;
    assign cam_data   = data_q;
    assign frame_done = done_q;
    assign underrun   = under_q;
    assign busy       = busy_q;

endmodule

// File: doc/dvp_frame_gen.md
# dvp_frame_gen

DVP camera-side transmitter: emits OV7725-style 8-bit RGB565 video (vsync, href, data bytes) on one clock, acting as the source end of the camera capture interface. It feeds `cmos_capture_data` in camera-less bench and loopback builds, with the block's `clk` also driving the receiver's `cam_pclk`. Pixels come from an upstream valid/ready stream or, when compiled in, a built-in colour-bar generator.

## Interface
- `H_PIXEL`, 640, active pixels per line.
- `V_PIXEL`, 480, active lines per frame.
- `H_BLANK`, 160, href-low clocks after each active line.
- `VS_LINES`, 3, lines with vsync high.
- `V_BACK`, 17, blank lines after vsync, before the first active line.
- `V_FRONT`, 10, blank lines after the last active line.
- `clk` in 1: pixel/byte clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run continuous frames while high.
- `pattern_sel` in 1: 1 selects the internal colour bars (feature macro only).
- `pix_valid` in 1: upstream pixel valid.
- `pix_data` in 16: upstream RGB565 pixel.
- `pix_ready` out 1: pixel accepted this clock when `pix_valid` is also high.
- `cam_vsync` out 1: frame sync, active high.
- `cam_href` out 1: line valid.
- `cam_data` out 8: byte data.
- `frame_done` out 1: one-clock pulse at the end of each frame.
- `underrun` out 1: sticky; a pixel was missing during an active line.
- `busy` out 1: a frame is in progress.

## Operation
- Line length: LINE_CLKS = 2*H_PIXEL + H_BLANK. Frame length: VS_LINES + V_BACK + V_PIXEL + V_FRONT lines.
- Counters:
  - `hcnt`: 0..LINE_CLKS-1.
  - `vcnt`: line within the current state.
  - `phase` bit: pixel byte select.
- States and transitions:
  - IDLE -> VSYNC when `en` is sampled high.
  - VSYNC (VS_LINES lines) -> VBACK.
  - VBACK (V_BACK lines) -> ACTIVE.
  - ACTIVE (V_PIXEL lines; each line is 2*H_PIXEL href-high clocks then H_BLANK href-low clocks) -> VFRONT.
  - VFRONT (V_FRONT lines) -> VSYNC if `en` is high, else IDLE.
- A zero-length V_BACK or V_FRONT state is skipped.
- Byte order per pixel: high byte `{R[4:0],G[5:3]}` first, then low byte `{G[2:0],B[4:0]}`.
- Pixel handshake:
  - `pix_ready` is combinational and high only on the even-byte clocks of ACTIVE href-high, in stream mode.
  - Handshake occurs when `pix_valid` and `pix_ready` are both high.
  - If `pix_valid` is low at a ready clock, the pixel is sent as 16'h0000 and `underrun` is set.
  - `underrun` clears only on `rst`.
- `cam_data` is 8'h00 whenever `cam_href` is low.
- `en` low mid-frame: the current frame completes, `frame_done` pulses, then the block enters IDLE. Outputs stay low in IDLE.
- `rst` mid-operation: the state machine goes to IDLE and all counters clear on that edge. No partial-frame completion.
- `pattern_sel` is sampled only on the IDLE->VSYNC and VFRONT->VSYNC transitions. It is held constant for the whole frame.

## Timing
- Reset values: all outputs 0; `underrun` 0.
- Outputs are registered one clock behind the internal counters. A pixel accepted at edge k drives its high byte at k+1 and its low byte at k+2.
- `cam_vsync` goes high at edge k+1, where k is the edge that samples `en` high in IDLE.
- `cam_href` is high for exactly 2*H_PIXEL consecutive clocks per active line.
- `busy` is high from entry to VSYNC until `frame_done`.
- `frame_done` coincides with the clock after the last VFRONT clock appears on the pins.

## Configuration
- `DVP_FRAME_GEN_PATTERN_EN` defined:
  - With `pattern_sel`=1, the block emits 8 vertical bars, each H_PIXEL/8 wide: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - `pix_ready` stays 0 and `underrun` is not set.
- Macro undefined:
  - The bar logic is absent and `pattern_sel` is ignored.
  - The block is always in stream mode.

## Structure
- Shared package `dvp_pkg`:
  - State enum.
  - RGB565 bar-colour constants.
  - Helper function for counter width: $clog2 of max(LINE_CLKS, lines).
- One sub-module, `dvp_bar_pattern`, instantiated only under the macro. It maps pixel x-position to an RGB565 colour.

## Test plan
Bench parameters unless noted: H_PIXEL=4, V_PIXEL=2, H_BLANK=2, VS_LINES=1, V_BACK=1, V_FRONT=1, giving LINE_CLKS=10 and a 50-clock frame.

- Continuous stream with `en`=1 and pixels 16'h1234, 16'h5678, … -> `cam_vsync` high for 10 clocks; `cam_href` high for 8 clocks per line on lines 2 and 3; bytes 12, 34, 56, 78, …; `frame_done` every 50 clocks.
- `pix_valid` low for the second pixel of line 2 -> bytes 00, 00 in that slot; `underrun`=1 and stays high; href timing unchanged.
- `en` dropped during line 2 -> frame completes, `frame_done` pulses, `busy`=0, `cam_vsync` stays 0.
- `rst` asserted mid-href -> all outputs 0 on the next clock; `en` high afterwards restarts the frame with vsync.
- Macro defined, H_PIXEL=8, `pattern_sel`=1 -> line bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00; `pix_ready` stays 0.
- Backpressure from an always-valid source with `pattern_sel`=0 -> exactly H_PIXEL handshakes per line and V_PIXEL*H_PIXEL per frame.
